// File: rtl/fp_hazard_unit.sv
// fp_hazard_unit
// Hazard and forwarding control for the 5-stage core with a multi-cycle FP
// execute path.
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   Rs1D/Rs2D             : Decode-stage source addresses
//   Rs1E/Rs2E/RdE         : Execute-stage source/destination addresses
//   RdM/RdW               : Memory/Writeback destination addresses
//   RegWriteM/RegWriteW   : Memory/Writeback register-file write enables
//   LoadE, PCSrcE         : Execute-stage load flag, taken branch/jump
//   IsFpE, FpOpE          : Execute-stage FP flag and FP op code
//   StallF/StallD/StallE  : hold PC, IF_ID, ID_EX
//   FlushD/FlushE/FlushM  : clear IF_ID, ID_EX, EX_MEM
//   ForwardAE/ForwardBE   : operand select (00 RF, 01 ResultW, 10 ALUResultM)
//   FpBusyE               : FP occupancy FSM is BUSY
//   FpStallCycles         : saturating count of FP-induced stall cycles
module fp_hazard_unit #(
    parameter int ADD_LAT = 0,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        IsFpE,
    input  logic [1:0]  FpOpE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        FpBusyE,
    output logic [15:0] FpStallCycles
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CNT_W-1:0] lat_n;
    logic             fp_start;
    logic             fp_stall;
    logic             lw_stall;

    // M has priority over W; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (rs == RdM))
            return 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (rs == RdW))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(Rs1E);
        ForwardBE = fwd_sel(Rs2E);
    end

    always_comb begin
        case (FpOpE)
            2'b10:   lat_n = CNT_W'(MUL_LAT);
            2'b11:   lat_n = CNT_W'(DIV_LAT);
            default: lat_n = CNT_W'(ADD_LAT);
        endcase
    end

    assign lw_stall = LoadE && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign fp_start = IsFpE && (lat_n != '0) && (state == IDLE);
    // The IDLE start cycle counts as the first hold cycle, so BUSY holds
    // only while cnt!=0; the cnt==0 cycle lets the FP op leave EX.
    assign fp_stall = fp_start || ((state == BUSY) && (cnt != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (fp_start) begin
                    cnt_next   = lat_n - CNT_W'(1);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0)
                    cnt_next = cnt - CNT_W'(1);
                else
                    state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (!reset) begin
            StallF = lw_stall || fp_stall;
            StallD = lw_stall || fp_stall;
            StallE = fp_stall;
            FlushM = fp_stall;
            FlushE = (lw_stall || PCSrcE) && !fp_stall;
            FlushD = PCSrcE && !fp_stall;
        end
    end

    assign FpBusyE = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset)
            FpStallCycles <= '0;
        else if (fp_stall && (FpStallCycles != 16'hFFFF))
            FpStallCycles <= FpStallCycles + 16'd1;
    end

endmodule
